// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cache line-port arbiter.
package cache_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one lower-level line port between the I-cache and D-cache.
//
//   state   | meaning
//   IDLE    | evaluate requests, latch the winner's address/op/data
//   GRANT_I | I-cache line fill in flight on the mem port
//   GRANT_D | D-cache fill or writeback in flight on the mem port
//   RELEASE | one dead cycle so the served cache can drop its request
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    arb_state_t        state_q, state_d;
    grant_t            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              i_req, d_req, granted;

    assign i_req = i_read_i;
    assign d_req = d_read_i | d_write_i;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        i_resp_o = 1'b0;
        d_resp_o = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, whoever was not served last wins.
                if (i_req && (!d_req || last_q == GNT_D)) begin
                    state_d = GRANT_I;
                    addr_d  = i_address_i;
                    wdata_d = '0;
                    write_d = 1'b0;
                end else if (d_req) begin
                    state_d = GRANT_D;
                    addr_d  = d_address_i;
                    wdata_d = d_wdata_i;
                    write_d = d_write_i;
                end
            end
            GRANT_I: begin
                if (mem_resp_i) begin
                    i_resp_o = !rst;
                    state_d  = RELEASE;
                    last_d   = GNT_I;
                end
            end
            GRANT_D: begin
                if (mem_resp_i) begin
                    d_resp_o = !rst;
                    state_d  = RELEASE;
                    last_d   = GNT_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GNT_D;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Mem port is quiet (all zero) outside a grant and while reset is held.
    assign granted       = !rst && (state_q == GRANT_I || state_q == GRANT_D);
    assign mem_read_o    = granted && !write_q;
    assign mem_write_o   = granted && write_q;
    assign mem_address_o = granted ? addr_q : '0;
    assign mem_wdata_o   = granted ? wdata_q : '0;

    assign i_line_o = mem_rdata_i;
    assign d_line_o = mem_rdata_i;

endmodule
